// File: rtl/hex_display_ctrl.sv
// Binary-to-BCD converter (double dabble, one bit per cycle) feeding six decode7 digits.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module hex_display_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [23:0] digits,
  output logic [5:0]  blank,
  output logic        ovf
);

  // state  | meaning
  // IDLE   | waiting for load, outputs hold
  // SHIFT  | one double-dabble iteration per cycle, 20 cycles
  // COMMIT | publish digits/blank/ovf, pulse done
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [19:0] work_q, work_d;
  logic [23:0] bcd_q, bcd_d;
  logic [23:0] bcd_adj;
  logic [4:0]  cnt_q, cnt_d;
  logic        big_q, big_d;
  logic [23:0] digits_q, digits_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    big_d    = big_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          work_d  = value;
          bcd_d   = '0;
          cnt_d   = '0;
          big_d   = (value > 20'd999999);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, work_d} = {bcd_adj[22:0], work_q, 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) state_d = COMMIT;
      end
      COMMIT: begin
        done_d   = 1'b1;
        ovf_d    = big_q;
        digits_d = big_q ? {6{4'd11}} : bcd_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      big_q    <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      big_q    <= big_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic [5:0] blank_q, blank_d;
  logic [5:0] lz;

  // A digit is dark only if it and every digit above it are zero; digit 0 always lit.
  always_comb begin
    lz    = '0;
    lz[5] = (bcd_q[23:20] == 4'd0);
    for (int i = 4; i >= 1; i--) begin
      lz[i] = lz[i+1] && (bcd_q[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    blank_d = blank_q;
    if (state_q == COMMIT) blank_d = big_q ? 6'b000000 : lz;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blank_q <= 6'b111110;
    else       blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = 6'b000000;
`endif

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign digits = digits_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: expected results are queued at load time
// from a decimal model and popped when done pulses.
module tb_hex_display_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] value;
  logic        load;
  logic        busy;
  logic        done;
  logic [23:0] digits;
  logic [5:0]  blank;
  logic        ovf;

  hex_display_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .digits(digits),
    .blank (blank),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [5:0] BLANK_RST = 6'b111110;
`else
  localparam logic [5:0] BLANK_RST = 6'b000000;
`endif

  typedef struct packed {
    logic [23:0] digits;
    logic [5:0]  blank;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input int unsigned v);
    exp_t        e;
    int unsigned t;
    e = '0;
    t = v;
    if (v > 999999) begin
      e.digits = {6{4'hB}};
      e.ovf    = 1'b1;
    end else begin
      for (int i = 0; i < 6; i++) begin
        e.digits[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
`ifdef LEAD_ZERO_BLANK_EN
      for (int i = 1; i < 6; i++) begin
        e.blank[i] = 1'b1;
        for (int j = i; j < 6; j++) if (e.digits[4*j +: 4] != 4'd0) e.blank[i] = 1'b0;
      end
`endif
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_digits"}, 32'(digits), 32'(e.digits));
      check({tag, "_blank"},  32'(blank),  32'(e.blank));
      check({tag, "_ovf"},    32'(ovf),    32'(e.ovf));
    end
  endtask

  // Starts one conversion; optionally fires a second load while busy at cycle ignore_at.
  task automatic convert(input logic [19:0] v, input int ignore_at, input string tag);
    int          n;
    bit          seen;
    logic [23:0] prev;
    @(negedge clk);
    prev  = digits;
    value = v;
    load  = 1'b1;
    sb.push_back(model(v));
    @(negedge clk);
    load  = 1'b0;
    value = 20'hABCDE;
    n     = 1;
    seen  = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (n < 40 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (n == 11) check({tag, "_hold_mid"}, 32'(digits), 32'(prev));
        if (n == ignore_at) begin
          value = 20'd7;
          load  = 1'b1;
        end
        if (n == ignore_at + 1) load = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'd22);
    check_result(tag);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int n;
    int k;
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    #12;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    check("rst_blank",  32'(blank),  32'(BLANK_RST));
    @(negedge clk);
    reset = 1'b0;

    convert(20'd0,       0, "zero");
    convert(20'd123456,  0, "v123456");
    convert(20'd42,      0, "v42");
    convert(20'd999999,  0, "v999999");
    convert(20'd1000000, 0, "v1000000");
    convert(20'hFFFFF,   0, "vmax");

    convert(20'd500, 5, "busy_ignore");
    count_done(30, pulses);
    check("busy_ignore_extra_done", 32'(pulses), 32'd0);

    @(negedge clk);
    value = 20'd777;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    check("abort_digits", 32'(digits), 32'd0);
    check("abort_ovf",    32'(ovf),    32'd0);
    check("abort_blank",  32'(blank),  32'(BLANK_RST));
    @(negedge clk);
    reset = 1'b0;
    count_done(30, pulses);
    check("abort_no_done", 32'(pulses), 32'd0);
    convert(20'd31, 0, "after_abort");

    @(negedge clk);
    value = 20'd65535;
    load  = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(32'd65535));
    n = 0;
    k = 0;
    while (k < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (done) begin
        check("hold_interval", 32'(n), 32'(22 * (k + 1)));
        check_result("hold");
        k++;
        if (k == 3) load = 1'b0;
      end
    end
    load = 1'b0;
    check("hold_count", 32'(k), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port value, input, 20 bits: unsigned binary number to display; sampled only on an accepted load.
REQ-004 The block SHALL have port load, input, 1 bit: conversion request; accepted only when busy=0.
REQ-005 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-006 The block SHALL have port done, output, 1 bit: single-cycle pulse when the digits, blank and ovf outputs update.
REQ-007 The block SHALL have port digits, output, 24 bits: six 4-bit decode7 codes; digit 0 (least significant) is at [3:0] and digit 5 is at [23:20].
REQ-008 The block SHALL have port blank, output, 6 bits: per-digit blank mask; bit i=1 means digit i is driven dark.
REQ-009 The block SHALL have port ovf, output, 1 bit: the last converted value exceeded 999999.

Function
REQ-010 The block SHALL be a state machine with states IDLE, SHIFT and COMMIT; busy SHALL be 1 exactly in SHIFT and COMMIT.
REQ-011 In IDLE with load=1, the block SHALL capture value into a working register, clear a 5-bit iteration counter and the 24-bit BCD accumulator, and enter SHIFT.
REQ-012 In IDLE with load=0, the block SHALL remain in IDLE and all outputs SHALL hold.
REQ-013 Each SHIFT cycle SHALL perform one double-dabble iteration: add 3 to every BCD nibble greater than or equal to 5, then shift {BCD, working} left by 1; the counter SHALL increment.
REQ-014 After the 20th SHIFT iteration (counter = 19) the block SHALL enter COMMIT; SHIFT SHALL last exactly 20 cycles.
REQ-015 In COMMIT the block SHALL register digits, blank and ovf, assert done for that one cycle, and return to IDLE.
REQ-016 Latency SHALL be fixed: done is high in the 22nd cycle after the load-accepting edge, and the new outputs are visible in that same cycle.
REQ-017 A load while busy=1 SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-018 A load in the cycle after done (IDLE) SHALL be accepted; the back-to-back throughput SHALL be one conversion per 22 cycles.
REQ-019 If the captured value is greater than 999999, COMMIT SHALL set every digit to 4'd11 (dash), blank to 6'b000000 and ovf to 1; otherwise ovf SHALL be 0.
REQ-020 Outputs SHALL never change outside COMMIT or reset, so downstream decode7 instances see no intermediate BCD values.

Reset
REQ-021 Asserting reset SHALL immediately force IDLE, busy=0, done=0, digits=24'h000000, ovf=0, and blank=6'b111110 when LEAD_ZERO_BLANK_EN is defined or 6'b000000 when it is not.
REQ-022 Reset during SHIFT or COMMIT SHALL abort the conversion with no done pulse; after reset deasserts, the first load SHALL start a fresh conversion.

Configuration
REQ-023 When macro LEAD_ZERO_BLANK_EN is defined, for i = 1..5 blank[i] SHALL be 1 iff digit i and all higher digits are 0; blank[0] SHALL always be 0.
REQ-024 When LEAD_ZERO_BLANK_EN is undefined, blank SHALL be constant 6'b000000 and no blanking logic SHALL be synthesized.
REQ-025 In both configurations, an overflow result SHALL have blank = 6'b000000.

Verification
REQ-026 Reset, then load value=0 -> done at cycle 22, digits=24'h000000, ovf=0, blank=6'b111110 with EN or 6'b000000 without.
REQ-027 Load value=123456 -> digits=24'h123456, blank=6'b000000, ovf=0; load value=42 -> digits=24'h000042, blank=6'b111100 with EN.
REQ-028 Load value=999999 -> digits=24'h999999, ovf=0; load value=1000000 -> digits=24'hBBBBBB, ovf=1, blank=6'b000000.
REQ-029 Load 500, then pulse load with value=7 at cycle 5 -> one done pulse at cycle 22 with digits=24'h000500; the second request is ignored.
REQ-030 Load 777, assert reset at cycle 10 -> outputs at reset values, no done pulse; a later load of 31 -> digits=24'h000031 after 22 cycles.
REQ-031 Hold load=1 continuously with value=65535 -> done pulses every 22 cycles, digits=24'h065535 each time.
